// File: rtl/nanoz80_pkg.sv
// Shared types and defaults for the nanoZ80 memory subsystem: arbiter FSM
// states, grant encoding and the default RAM geometry.
package nanoz80_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CPU_ACC  = 3'd1,
    ST_CPU_DONE = 3'd2,
    ST_DMA_ACC  = 3'd3,
    ST_DMA_DONE = 3'd4
  } arb_state_e;

  typedef enum logic {
    GRANT_CPU = 1'b0,
    GRANT_DMA = 1'b1
  } grant_e;

endpackage

// File: rtl/ram_arbiter.sv
// Shares one synchronous RAM between the Z80 (upper 32 KiB, held off with WAIT)
// and a DMA requester; one RAM access per grant, alternating under contention.
module ram_arbiter
  import nanoz80_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cpu_cs_i,
  input  logic              cpu_rd_n_i,
  input  logic              cpu_wr_n_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              cpu_wait_n_o,
  input  logic              dma_req_i,
  input  logic              dma_we_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [DATA_W-1:0] dma_data_i,
  output logic              dma_ack_o,
  output logic [DATA_W-1:0] dma_data_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i
);

  arb_state_e state, next_state;
  grant_e     last_grant;
  logic       served;
  logic       cpu_abort;
  logic       cur_we;
  logic       cpu_pending;
  logic       grant_cpu;
  logic       grant_dma;

  // served marks "this Z80 bus cycle already got its RAM access".
  assign cpu_pending  = cpu_cs_i & (~cpu_rd_n_i | ~cpu_wr_n_i) & ~served;
  assign cpu_wait_n_o = ~(cpu_cs_i & ~served);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the clock edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= ST_IDLE;
    else          state <= next_state;
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    next_state = state;
    grant_cpu  = 1'b0;
    grant_dma  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cpu_pending && (!dma_req_i || last_grant == GRANT_DMA)) begin
          grant_cpu  = 1'b1;
          next_state = ST_CPU_ACC;
        end else if (dma_req_i) begin
          grant_dma  = 1'b1;
          next_state = ST_DMA_ACC;
        end
      end
      ST_CPU_ACC:  next_state = ST_CPU_DONE;
      ST_CPU_DONE: next_state = ST_IDLE;
      ST_DMA_ACC:  next_state = ST_DMA_DONE;
      ST_DMA_DONE: next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ram_en_o   <= 1'b0;
      ram_we_o   <= 1'b0;
      ram_addr_o <= '0;
      ram_data_o <= '0;
      cpu_data_o <= '0;
      dma_data_o <= '0;
      dma_ack_o  <= 1'b0;
      cur_we     <= 1'b0;
      served     <= 1'b0;
      cpu_abort  <= 1'b0;
      last_grant <= GRANT_DMA;
    end else begin
      ram_en_o  <= grant_cpu | grant_dma;
      ram_we_o  <= (grant_cpu & ~cpu_wr_n_i) | (grant_dma & dma_we_i);
      dma_ack_o <= (state == ST_DMA_DONE);

      if (grant_cpu) begin
        ram_addr_o <= cpu_addr_i;
        ram_data_o <= cpu_data_i;
        cur_we     <= ~cpu_wr_n_i;
        last_grant <= GRANT_CPU;
      end else if (grant_dma) begin
        ram_addr_o <= dma_addr_i;
        ram_data_o <= dma_data_i;
        cur_we     <= dma_we_i;
        last_grant <= GRANT_DMA;
      end

      if (state == ST_CPU_DONE && !cur_we) cpu_data_o <= ram_data_i;
      if (state == ST_DMA_DONE && !cur_we) dma_data_o <= ram_data_i;

      // A chip-select drop anywhere inside the access means the Z80 abandoned
      // that bus cycle; it must not be marked served on completion.
      if (grant_cpu)     cpu_abort <= 1'b0;
      else if (!cpu_cs_i) cpu_abort <= 1'b1;

      if (!cpu_cs_i)                                served <= 1'b0;
      else if (state == ST_CPU_DONE && !cpu_abort)  served <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: drivers push expected read data from a
// reference memory, a negedge monitor pops and compares on CPU release / DMA ack.
module tb_ram_arbiter;

  localparam int AW = 15;
  localparam int DW = 8;

  logic          clk_i      = 1'b0;
  logic          rst_n_i    = 1'b0;
  logic          cpu_cs_i   = 1'b0;
  logic          cpu_rd_n_i = 1'b1;
  logic          cpu_wr_n_i = 1'b1;
  logic [AW-1:0] cpu_addr_i = '0;
  logic [DW-1:0] cpu_data_i = '0;
  logic [DW-1:0] cpu_data_o;
  logic          cpu_wait_n_o;
  logic          dma_req_i  = 1'b0;
  logic          dma_we_i   = 1'b0;
  logic [AW-1:0] dma_addr_i = '0;
  logic [DW-1:0] dma_data_i = '0;
  logic          dma_ack_o;
  logic [DW-1:0] dma_data_o;
  logic          ram_en_o;
  logic          ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_data_o;
  logic [DW-1:0] ram_rdata  = '0;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .cpu_cs_i     (cpu_cs_i),
    .cpu_rd_n_i   (cpu_rd_n_i),
    .cpu_wr_n_i   (cpu_wr_n_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_data_i   (cpu_data_i),
    .cpu_data_o   (cpu_data_o),
    .cpu_wait_n_o (cpu_wait_n_o),
    .dma_req_i    (dma_req_i),
    .dma_we_i     (dma_we_i),
    .dma_addr_i   (dma_addr_i),
    .dma_data_i   (dma_data_i),
    .dma_ack_o    (dma_ack_o),
    .dma_data_o   (dma_data_o),
    .ram_en_o     (ram_en_o),
    .ram_we_o     (ram_we_o),
    .ram_addr_o   (ram_addr_o),
    .ram_data_o   (ram_data_o),
    .ram_data_i   (ram_rdata)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic          we;
    logic [DW-1:0] data;
  } dma_exp_t;

  int            checks = 0;
  int            errors = 0;
  int            cycle  = 0;
  logic [DW-1:0] cpu_q[$];
  dma_exp_t      dma_q[$];
  logic [DW-1:0] ref_mem[int];
  logic [DW-1:0] tb_mem[int];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Power-up contents of never-written RAM words.
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a[7:0] ^ a[14:7] ^ 8'h5A;
  endfunction

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction

  // Synchronous RAM the arbiter drives: read data valid one cycle after enable.
  always @(posedge clk_i) begin
    cycle++;
    if (ram_en_o) begin
      ram_rdata <= tb_mem.exists(int'(ram_addr_o)) ? tb_mem[int'(ram_addr_o)] : init_val(ram_addr_o);
      if (ram_we_o) tb_mem[int'(ram_addr_o)] = ram_data_o;
    end
  end

  // Monitor: protocol checks plus scoreboard pops.
  logic     prev_en  = 1'b0;
  logic     prev_ack = 1'b0;
  logic     cpu_seen = 1'b0;
  int       en_count = 0;
  int       we_count = 0;
  int       ack_count = 0;
  int       release_cycle = 0;
  int       ack_cycle = 0;
  logic     grant_log[$];
  dma_exp_t mon_e;

  always @(negedge clk_i) begin
    if (!rst_n_i) begin
      prev_en  = 1'b0;
      prev_ack = 1'b0;
      cpu_seen = 1'b0;
    end else begin
      if (ram_en_o) begin
        check("ram_en_gap", prev_en, 0);
        en_count++;
        grant_log.push_back(ram_addr_o[14]);
      end
      if (ram_we_o) begin
        we_count++;
        check("ram_we_with_en", ram_en_o, 1);
      end
      prev_en = ram_en_o;

      if (dma_ack_o) begin
        ack_count++;
        ack_cycle = cycle;
        check("dma_ack_pulse", prev_ack, 0);
        check("dma_ack_expected", dma_q.size() > 0, 1);
        if (dma_q.size() > 0) begin
          mon_e = dma_q.pop_front();
          if (!mon_e.we) check("dma_rdata", dma_data_o, mon_e.data);
        end
      end
      prev_ack = dma_ack_o;

      if (!cpu_cs_i) cpu_seen = 1'b0;
      else if (cpu_wait_n_o && !cpu_seen) begin
        cpu_seen      = 1'b1;
        release_cycle = cycle;
        if (!cpu_rd_n_i) begin
          check("cpu_read_expected", cpu_q.size() > 0, 1);
          if (cpu_q.size() > 0) check("cpu_rdata", cpu_data_o, cpu_q.pop_front());
        end
      end
    end
  end

  // One Z80 bus cycle; lat counts negedges until WAIT releases.
  task automatic cpu_access(input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, output int lat);
    bit got = 1'b0;
    @(negedge clk_i); #1;
    cpu_cs_i   = 1'b1;
    cpu_addr_i = addr;
    cpu_data_i = data;
    cpu_wr_n_i = ~we;
    cpu_rd_n_i = we;
    if (we) ref_mem[int'(addr)] = data;
    else    cpu_q.push_back(ref_rd(addr));
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      lat++;
      if (cpu_wait_n_o) begin
        got = 1'b1;
        break;
      end
    end
    check("cpu_wait_release", got, 1);
    #1;
    cpu_cs_i   = 1'b0;
    cpu_rd_n_i = 1'b1;
    cpu_wr_n_i = 1'b1;
  endtask

  // Called at negedge+1; leaves dma_req_i high so the caller can chain or drop it.
  task automatic dma_access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    dma_exp_t e;
    bit got = 1'b0;
    dma_req_i  = 1'b1;
    dma_we_i   = we;
    dma_addr_i = addr;
    dma_data_i = data;
    e.we   = we;
    e.data = we ? data : ref_rd(addr);
    dma_q.push_back(e);
    if (we) ref_mem[int'(addr)] = data;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      if (dma_ack_o) begin
        got = 1'b1;
        break;
      end
    end
    check("dma_ack_arrives", got, 1);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk_i); #1;
    rst_n_i   = 1'b0;
    cpu_cs_i  = 1'b0;
    dma_req_i = 1'b0;
    cpu_q.delete();
    dma_q.delete();
    repeat (2) @(negedge clk_i);
    #1 rst_n_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    int w0;
    int e0;
    int a0;

    // Reset values while reset is held.
    #12;
    check("rst_ram_en", ram_en_o, 0);
    check("rst_ram_we", ram_we_o, 0);
    check("rst_ram_addr", ram_addr_o, 0);
    check("rst_ram_data", ram_data_o, 0);
    check("rst_cpu_data", cpu_data_o, 0);
    check("rst_dma_data", dma_data_o, 0);
    check("rst_dma_ack", dma_ack_o, 0);
    check("rst_wait_n", cpu_wait_n_o, 1);
    @(negedge clk_i); #1 rst_n_i = 1'b1;

    // CPU read of a word placed by DMA; WAIT released after three clocks.
    @(negedge clk_i); #1;
    dma_access(1'b1, 15'h0123, 8'hA5);
    dma_req_i = 1'b0;
    cpu_access(1'b0, 15'h0123, 8'h00, lat);
    check("cpu_read_latency", lat, 3);

    // CPU write at the top address, single write strobe, then read back.
    w0 = we_count;
    cpu_access(1'b1, 15'h7FFF, 8'h3C, lat);
    check("cpu_write_we_pulses", we_count - w0, 1);
    cpu_access(1'b0, 15'h7FFF, 8'h00, lat);

    // Simultaneous CPU and DMA after reset: CPU first, DMA ack 3 clocks later.
    apply_reset();
    grant_log.delete();
    fork
      cpu_access(1'b0, 15'h0010, 8'h00, lat);
      begin
        @(negedge clk_i); #1;
        dma_access(1'b0, 15'h4020, 8'h00);
        dma_req_i = 1'b0;
      end
    join
    check("contend_grant_count", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      check("contend_first_cpu", grant_log[0], 0);
      check("contend_second_dma", grant_log[1], 1);
    end
    check("contend_ack_delay", ack_cycle - release_cycle, 3);

    // Continuous DMA against back-to-back CPU cycles: grants alternate.
    grant_log.delete();
    fork
      for (int i = 0; i < 6; i++)
        cpu_access(1'($urandom_range(0, 1)), 15'h0040 + 15'($urandom_range(0, 15)),
                   8'($urandom), lat);
      begin
        @(negedge clk_i); #1;
        for (int i = 0; i < 6; i++)
          dma_access(1'($urandom_range(0, 1)), 15'h4040 + 15'($urandom_range(0, 15)), 8'($urandom));
        dma_req_i = 1'b0;
      end
    join
    check("alt_grant_count", grant_log.size(), 12);
    for (int i = 1; i < grant_log.size(); i++)
      check("alt_grant_order", grant_log[i] != grant_log[i-1], 1);

    // Chip select dropped during the access: write still lands, next cycle normal.
    e0 = en_count;
    @(negedge clk_i); #1;
    cpu_cs_i   = 1'b1;
    cpu_wr_n_i = 1'b0;
    cpu_addr_i = 15'h0200;
    cpu_data_i = 8'h77;
    ref_mem[int'(15'h0200)] = 8'h77;
    @(negedge clk_i); #1;
    cpu_cs_i   = 1'b0;
    cpu_wr_n_i = 1'b1;
    repeat (4) @(negedge clk_i);
    check("abort_access_done", en_count - e0, 1);
    cpu_access(1'b0, 15'h0200, 8'h00, lat);
    check("after_abort_latency", lat, 3);

    // Reset in the middle of a DMA write: outputs clear at once, no ack, no write.
    a0 = ack_count;
    @(negedge clk_i); #1;
    dma_req_i  = 1'b1;
    dma_we_i   = 1'b1;
    dma_addr_i = 15'h4100;
    dma_data_i = 8'h99;
    @(negedge clk_i);
    check("dma_in_access", ram_en_o, 1);
    #1;
    rst_n_i   = 1'b0;
    dma_req_i = 1'b0;
    #1;
    check("midrst_ram_en", ram_en_o, 0);
    check("midrst_ram_we", ram_we_o, 0);
    check("midrst_ram_addr", ram_addr_o, 0);
    check("midrst_ram_data", ram_data_o, 0);
    check("midrst_dma_ack", dma_ack_o, 0);
    repeat (2) @(negedge clk_i);
    #1 rst_n_i = 1'b1;
    repeat (6) @(negedge clk_i);
    check("midrst_no_ack", ack_count - a0, 0);
    check("midrst_no_write", tb_mem.exists(int'(15'h4100)), 0);

    // Randomised traffic from both requesters with random idle gaps.
    fork
      for (int i = 0; i < 30; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk_i);
        cpu_access(1'($urandom_range(0, 1)), 15'h0040 + 15'($urandom_range(0, 15)),
                   8'($urandom), lat);
      end
      begin
        @(negedge clk_i); #1;
        for (int i = 0; i < 30; i++) begin
          int gap;
          dma_access(1'($urandom_range(0, 1)), 15'h4040 + 15'($urandom_range(0, 15)), 8'($urandom));
          gap = $urandom_range(0, 3);
          if (gap > 0) begin
            dma_req_i = 1'b0;
            repeat (gap) @(negedge clk_i);
            #1;
          end
        end
        dma_req_i = 1'b0;
      end
    join
    repeat (5) @(negedge clk_i);
    check("cpu_q_drained", cpu_q.size(), 0);
    check("dma_q_drained", dma_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 15, RAM word-address width (32 KiB upper half).
REQ-002 Parameter DATA_W, default 8, data width.
REQ-003 clk_i  in  1  system clock; all state on rising edge.
REQ-004 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-005 cpu_cs_i  in  1  RAM select from address decoder (mreq_n low, addr[15] high).
REQ-006 cpu_rd_n_i / cpu_wr_n_i  in  1 each  Z80 read/write strobes, active-low.
REQ-007 cpu_addr_i  in  ADDR_W  Z80 address bits [14:0].
REQ-008 cpu_data_i  in  DATA_W  Z80 write data.
REQ-009 cpu_data_o  out  DATA_W  registered CPU read data.
REQ-010 cpu_wait_n_o  out  1  Z80 WAIT, active-low.
REQ-011 dma_req_i  in  1  secondary requester request, level, held until ack.
REQ-012 dma_we_i, dma_addr_i, dma_data_i  in  1/ADDR_W/DATA_W  DMA write-enable, address, write data; stable while dma_req_i high.
REQ-013 dma_ack_o  out  1  one-cycle completion pulse.
REQ-014 dma_data_o  out  DATA_W  registered DMA read data, valid with dma_ack_o.
REQ-015 ram_en_o, ram_we_o  out  1 each  registered RAM enable and write strobe.
REQ-016 ram_addr_o, ram_data_o  out  ADDR_W/DATA_W  registered RAM address, write data.
REQ-017 ram_data_i  in  DATA_W  synchronous RAM read data, valid one cycle after ram_en_o.

Function
REQ-018 CPU pending = cpu_cs_i & (~cpu_rd_n_i | ~cpu_wr_n_i) & ~served; served is an internal flag.
REQ-019 FSM states IDLE, CPU_ACC, CPU_DONE, DMA_ACC, DMA_DONE; one RAM access per grant.
REQ-020 IDLE: one requester pending -> grant it; both pending -> grant requester opposite to last_grant; none -> stay IDLE, ram_en_o=0.
REQ-021 On grant at edge k: ram_en_o=1, ram_we_o=requester write, ram_addr_o/ram_data_o loaded; next state CPU_ACC or DMA_ACC; last_grant updated.
REQ-022 *_ACC: ram_en_o=0, ram_we_o=0 at edge k+1; next state *_DONE.
REQ-023 CPU_DONE at edge k+2: cpu_data_o<=ram_data_i on reads (unchanged on writes), served<=1, return IDLE.
REQ-024 DMA_DONE at edge k+2: dma_data_o<=ram_data_i on reads, dma_ack_o=1 for exactly that cycle, return IDLE.
REQ-025 cpu_wait_n_o = ~(cpu_cs_i & ~served), combinational; WAIT released the cycle after edge k+2.
REQ-026 served clears on any edge where cpu_cs_i is low; cpu_cs_i low >=1 clock between Z80 cycles.
REQ-027 cpu_cs_i dropping during CPU_ACC/CPU_DONE: access completes, no served set, no hang; dropped write still committed.
REQ-028 DMA request arriving during a CPU access waits; back-to-back contention alternates CPU/DMA; neither starves beyond one access.
REQ-029 dma_req_i sampled again no earlier than the IDLE cycle after dma_ack_o; requester may keep it high for the next transfer.
REQ-030 Minimum access period 3 clocks; no two ram_en_o pulses adjacent.

Reset
REQ-031 Async reset: state IDLE, ram_en_o=0, ram_we_o=0, ram_addr_o=0, ram_data_o=0, cpu_data_o=0, dma_data_o=0, dma_ack_o=0, served=0, last_grant=DMA (CPU wins first contention).
REQ-032 Reset mid-access aborts immediately; ram_we_o low asynchronously; no ack issued.

Structure
REQ-033 Shared package nanoz80_pkg holds FSM state enum, grant encoding, ADDR_W/DATA_W defaults.
REQ-034 Single flat module; no sub-module required.

Verification
REQ-035 CPU read: RAM[0x0123]=0xA5, cpu_cs_i+rd at edge k -> cpu_wait_n_o low, cpu_data_o=0xA5 and wait_n high after edge k+2.
REQ-036 CPU write 0x3C to 0x7FFF then read -> ram_we_o single pulse, readback 0x3C.
REQ-037 CPU and DMA pending same edge after reset -> CPU granted first, DMA ack exactly 3 clocks later.
REQ-038 Continuous DMA and repeated CPU cycles -> grants strictly alternate, each ack a one-cycle pulse.
REQ-039 cpu_cs_i dropped in CPU_ACC -> FSM returns IDLE, served=0, next CPU cycle serviced normally.
REQ-040 rst_n_i asserted during DMA_ACC -> all outputs at reset values same cycle, no dma_ack_o.
